// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types, recorder FSM states and mix helpers
package audio_pkg;

    // 8-bit signed sample as stored in RAM and replayed as {sample, 8'b0}
    typedef logic [7:0] sample8_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        DONE = 2'd2
    } rec_state_t;

    // Average of two signed samples; the 17-bit sum keeps the carry so
    // taking bits [16:1] is an arithmetic shift with no overflow.
    function automatic logic [15:0] mono_mix(input logic [15:0] l, input logic [15:0] r);
        logic [16:0] sum;
        sum = {l[15], l} + {r[15], r};
        return sum[16:1];
    endfunction

    // Unsigned magnitude; -32768 maps to 16'h8000, which is 32768 read as unsigned.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

endpackage

// File: rtl/rec_ram.sv
// rtl/rec_ram.sv - simple dual-port sample RAM, one write port, registered read port
module rec_ram
    import audio_pkg::*;
#(
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  sample8_t          wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output sample8_t          rd_data
);

    sample8_t mem [DEPTH];

    // Write port; contents are deliberately never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; a read colliding with a write returns the old byte
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/audio_recorder.sv
// rtl/audio_recorder.sv - mono sample recorder with clap detector and peak level meter
module audio_recorder
    import audio_pkg::*;
#(
    parameter int          DEPTH   = 16384,
    parameter int          ADDR_W  = 14,
    parameter logic [15:0] THRESH  = 16'd8192,
    parameter int          HOLDOFF = 4800,
    parameter int          DECAY   = 256
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic [15:0]       adc_data_l,
    input  logic [15:0]       adc_data_r,
    input  logic              data_ena,
    input  logic              rec_start,
    input  logic              rec_stop,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   rec_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              clap,
    output logic [7:0]        level
);

    localparam int LEN_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(HOLDOFF + 1);
    localparam int DEC_W  = $clog2(DECAY + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLDOFF);
    localparam logic [DEC_W-1:0]  DECAY_LAST = DEC_W'(DECAY - 1);

    rec_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [HOLD_W-1:0] holdoff_cnt;
    logic [DEC_W-1:0]  decay_cnt;

    logic [15:0] mono;
    logic [15:0] mag;
    sample8_t    wr_byte;
    logic        wr_en;

    // The codec already registers its samples, so the mix path is combinational
    assign mono    = mono_mix(adc_data_l, adc_data_r);
    assign mag     = abs16(mono);
    assign wr_byte = mono[15:8];
    // A restart discards the sample arriving on the same cycle
    assign wr_en   = (state == REC) && data_ena && !rec_start;

    rec_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk_50),
        .reset   (reset),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_byte),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Recording FSM: pointer, length, busy/full flags; start beats stop
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            full    <= 1'b0;
            wr_ptr  <= '0;
            rec_len <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (rec_start) begin
                        state   <= REC;
                        busy    <= 1'b1;
                        full    <= 1'b0;
                        wr_ptr  <= '0;
                        rec_len <= '0;
                    end
                end
                REC: begin
                    if (rec_start) begin
                        wr_ptr  <= '0;
                        rec_len <= '0;
                    end else begin
                        if (data_ena) begin
                            rec_len <= rec_len + LEN_W'(1);
                            // The pointer parks on the last slot instead of wrapping
                            if (wr_ptr == LAST_ADDR) begin
                                full  <= 1'b1;
                                state <= DONE;
                                busy  <= 1'b0;
                            end else begin
                                wr_ptr <= wr_ptr + ADDR_W'(1);
                            end
                        end
                        if (rec_stop) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Clap detector: one-cycle pulse, then ignore HOLDOFF samples
    always_ff @(posedge clk_50) begin
        if (reset) begin
            clap        <= 1'b0;
            holdoff_cnt <= '0;
        end else begin
            clap <= 1'b0;
            if (data_ena) begin
                if (holdoff_cnt != '0) begin
                    holdoff_cnt <= holdoff_cnt - HOLD_W'(1);
                end else if (mag >= THRESH) begin
                    clap        <= 1'b1;
                    holdoff_cnt <= HOLD_LOAD;
                end
            end
        end
    end

    // Peak meter: instant attack, one step down every DECAY samples
    always_ff @(posedge clk_50) begin
        if (reset) begin
            level     <= '0;
            decay_cnt <= '0;
        end else if (data_ena) begin
            decay_cnt <= (decay_cnt == DECAY_LAST) ? '0 : decay_cnt + DEC_W'(1);
            if (mag[15:8] > level) begin
                level <= mag[15:8];
            end else if (decay_cnt == DECAY_LAST && level != 8'd0) begin
                level <= level - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_audio_recorder.sv
// tb/tb_audio_recorder.sv - self-checking bench for audio_recorder
module tb_audio_recorder;

    localparam int ADDR_W = 4;

    logic              clk_50 = 1'b0;
    logic              reset;
    logic [15:0]       adc_data_l;
    logic [15:0]       adc_data_r;
    logic              data_ena;
    logic              rec_start;
    logic              rec_stop;
    logic              busy;
    logic              full;
    logic [ADDR_W:0]   rec_len;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              clap;
    logic [7:0]        level;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q [$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        stop;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [8];

    audio_recorder #(
        .DEPTH  (16),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_50     (clk_50),
        .reset      (reset),
        .adc_data_l (adc_data_l),
        .adc_data_r (adc_data_r),
        .data_ena   (data_ena),
        .rec_start  (rec_start),
        .rec_stop   (rec_stop),
        .busy       (busy),
        .full       (full),
        .rec_len    (rec_len),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .clap       (clap),
        .level      (level)
    );

    always #10 clk_50 = ~clk_50;

    task automatic tick();
        @(posedge clk_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        adc_data_l = l;
        adc_data_r = r;
        data_ena   = 1'b1;
        tick();
        data_ena   = 1'b0;
    endtask

    task automatic pulse_start();
        rec_start = 1'b1;
        tick();
        rec_start = 1'b0;
    endtask

    task automatic pulse_stop();
        rec_stop = 1'b1;
        tick();
        rec_stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic readback(input int n, input string name);
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            rd_addr = ADDR_W'(i);
            tick();
            if (exp_q.size() == 0) begin
                check({name, " queue_empty"}, 32'd1, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("%s addr%0d", name, i), rd_data, exp);
            end
        end
    endtask

    initial begin
        int clap_cnt;

        vecs[0] = '{16'h7F00, 16'h7F00, 1'b0, 8'h7F};
        vecs[1] = '{16'h8000, 16'h8000, 1'b0, 8'h80};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 8'h00};
        vecs[3] = '{16'h1234, 16'h0000, 1'b0, 8'h09};
        vecs[4] = '{16'hFF00, 16'hFF00, 1'b0, 8'hFF};
        vecs[5] = '{16'h8000, 16'h7FFF, 1'b0, 8'hFF};
        vecs[6] = '{16'h0101, 16'h0303, 1'b0, 8'h02};
        vecs[7] = '{16'h4000, 16'hC000, 1'b1, 8'h00};

        reset = 1'b1; adc_data_l = '0; adc_data_r = '0; data_ena = 1'b0;
        rec_start = 1'b0; rec_stop = 1'b0; rd_addr = '0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset full", full, 0);
        check("reset rec_len", rec_len, 0);
        check("reset clap", clap, 0);
        check("reset level", level, 0);
        check("reset rd_data", rd_data, 0);
        reset = 1'b0;

        // Samples without rec_start are metered but not recorded
        clap_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            send(16'h4000, 16'h4000);
            if (clap) clap_cnt++;
        end
        check("idle busy", busy, 0);
        check("idle rec_len", rec_len, 0);
        check("idle level", level, 8'h40);
        check("idle clap count", clap_cnt, 1);

        // Basic recording of five identical samples, then a separate stop
        do_reset();
        pulse_start();
        check("start busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            send(16'h1000, 16'h3000);
            exp_q.push_back(8'h20);
        end
        check("rec5 rec_len", rec_len, 5);
        pulse_stop();
        check("rec5 busy", busy, 0);
        check("rec5 full", full, 0);
        readback(5, "rec5");

        // Table-driven recording; the last vector carries a stop on the same cycle
        pulse_start();
        check("tbl rec_len cleared", rec_len, 0);
        for (int i = 0; i < 8; i++) begin
            rec_stop = vecs[i].stop;
            send(vecs[i].l, vecs[i].r);
            rec_stop = 1'b0;
            exp_q.push_back(vecs[i].exp_byte);
        end
        check("tbl rec_len", rec_len, 8);
        check("tbl busy", busy, 0);
        readback(8, "tbl");

        // Clap holdoff: pulse at sample 0, silence for 4800 loud samples, pulse at 4801
        do_reset();
        send(16'h8000, 16'h8000);
        check("clap first", clap, 1);
        check("clap level", level, 8'h80);
        tick();
        check("clap width", clap, 0);
        clap_cnt = 0;
        for (int i = 1; i <= 4800; i++) begin
            send(16'h8000, 16'h8000);
            if (clap) clap_cnt++;
        end
        check("clap holdoff quiet", clap_cnt, 0);
        send(16'h8000, 16'h8000);
        check("clap after holdoff", clap, 1);

        // Fill the 16-entry buffer with 20 samples
        do_reset();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            send({i[7:0], 8'h00}, {i[7:0], 8'h00});
            if (i < 16) exp_q.push_back(i[7:0]);
            if (i == 14) check("fill busy before last", busy, 1);
            if (i == 15) begin
                check("fill busy at last", busy, 0);
                check("fill full at last", full, 1);
            end
        end
        check("fill rec_len", rec_len, 16);
        check("fill full", full, 1);
        readback(16, "fill");
        pulse_stop();
        check("done stop ignored busy", busy, 0);
        check("done stop ignored len", rec_len, 16);
        pulse_start();
        check("restart full cleared", full, 0);
        check("restart busy", busy, 1);
        check("restart rec_len", rec_len, 0);

        // Start and stop together while recording: restart wins, sample discarded
        for (int i = 0; i < 3; i++) send(16'h5500, 16'h5500);
        check("pre-restart rec_len", rec_len, 3);
        rec_start = 1'b1;
        rec_stop  = 1'b1;
        send(16'h6600, 16'h6600);
        rec_start = 1'b0;
        rec_stop  = 1'b0;
        check("both busy", busy, 1);
        check("both rec_len", rec_len, 0);
        send(16'h1100, 16'h1100);
        exp_q.push_back(8'h11);
        send(16'h2200, 16'h2200);
        exp_q.push_back(8'h22);
        check("both after rec_len", rec_len, 2);
        readback(2, "both");

        // Reset mid-recording, then level attack and decay
        reset = 1'b1;
        tick();
        check("midreset busy", busy, 0);
        check("midreset full", full, 0);
        check("midreset rec_len", rec_len, 0);
        check("midreset clap", clap, 0);
        check("midreset level", level, 0);
        check("midreset rd_data", rd_data, 0);
        reset = 1'b0;
        send(16'h7F00, 16'h7F00);
        check("level attack", level, 8'h7F);
        for (int i = 0; i < 200; i++) send(16'h0000, 16'h0000);
        check("level hold", level, 8'h7F);
        for (int i = 0; i < 56; i++) send(16'h0000, 16'h0000);
        check("level decay", level, 8'h7E);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
